ecc_point_add: RTL
==================

# ecc_point_add

Sequential elliptic-curve point-addition stage over GF(p) for the curve y² = x³ + a·x + b. It collects two affine points, a prime and the curve coefficient a over a two-beat input handshake, and computes the slope using the team's combinational modular-inverse soft IP, `INV_IP`. It then produces R = P + Q, or R = 2P when P = Q, as a single-beat registered result. It sits directly downstream of the inverse IP and is the consumer of its output.

## Interface
- WIDTH, 6, bit width of every coordinate, the prime and a; passed to `INV_IP` as IP_WIDTH.
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  high for exactly 2 consecutive cycles per operation.
- in_x  in  WIDTH  beat 1: x1; beat 2: x2.
- in_y  in  WIDTH  beat 1: y1; beat 2: y2.
- in_prime  in  WIDTH  prime p, sampled on beat 1 only; 3 ≤ p < 2^WIDTH.
- in_a  in  WIDTH  curve coefficient a, sampled on beat 1 only; a < p.
- out_valid  out  1  high for exactly 1 cycle per operation.
- out_x  out  WIDTH  x3; 0 whenever out_valid is low.
- out_y  out  WIDTH  y3; 0 whenever out_valid is low.

## Operation
- FSM states: IDLE, BEAT2, PREP, SLOPE, XCALC, OUT.
  - IDLE→BEAT2 on in_valid (latch x1, y1, p, a).
  - BEAT2→PREP (latch x2, y2).
  - PREP, SLOPE, XCALC and OUT each advance unconditionally.
  - OUT→IDLE.
- PREP registers num and den:
  - Addition (x1≠x2 or y1≠y2): num = (y2−y1) mod p, den = (x2−x1) mod p.
  - Doubling (x1=x2 and y1=y2): num = (3·x1² + a) mod p, den = (2·y1) mod p.
- SLOPE: s = (num · inv) mod p, where inv is the output of `INV_IP` driven with IN_1 = den and IN_2 = p. Register s.
- XCALC: x3 = (s² − x1 − x2) mod p; register x3.
- OUT: y3 = (s·(x1 − x3) − y1) mod p; register out_x = x3, out_y = y3, out_valid = 1.
- Arithmetic rules:
  - All stored operands are < p.
  - Modular subtraction: a ≥ b ? a−b : a−b+p, computed in WIDTH+1 bits.
  - Products are 2·WIDTH bits, reduced with `%` p.
  - 3·x1² + a is held in 2·WIDTH+2 bits before reduction.
  - No intermediate value may truncate.
- Degenerate input (den = 0, i.e. P = −Q, or y1 = 0 when doubling) is outside the input contract. Required response: complete the normal sequence and output out_x = out_y = 0.
- in_valid asserted while the FSM is not in IDLE or BEAT2 is ignored. The bench never drives it there.

## Timing
- Reset (async assert, rst_n low): FSM = IDLE, out_valid = 0, out_x = 0, out_y = 0, all internal registers = 0.
- Latency is counted from edge E0, the edge that samples beat 2:
  - num/den are registered at E0+1.
  - s at E0+2.
  - x3 at E0+3.
  - Outputs at E0+4, so out_valid is high during the cycle following E0+4.
- Next operation: beat 1 may be sampled on the edge that ends the out_valid cycle (E0+5). The minimum spacing between first beats is therefore 6 cycles.
- out_x and out_y return to 0 at the same edge where out_valid falls.
- Reset asserted mid-operation aborts immediately:
  - No out_valid is produced for the aborted operation.
  - After release, the FSM accepts a fresh beat 1.

## Test plan
- Addition: p=17, a=2, beat 1 (5,1), beat 2 (6,3) → out_valid 4 edges after beat 2, out (10,6).
- Doubling: p=17, a=2, (5,1),(5,1) → (6,3). Checks the 3x²+a path and the inverse of 2·y1 = 2.
- Operand order and subtraction wrap: p=17, a=2, (6,3),(5,1) → (10,6). Exercises the negative-difference +p correction.
- Back-to-back: addition then doubling issued with minimum spacing (6 cycles) → two single-cycle out_valid pulses 6 cycles apart carrying (10,6) then (6,3). Outputs read 0 between the pulses.
- Reset mid-operation: assert rst_n low one cycle after beat 2 → all outputs 0 immediately and no out_valid. After release, a new addition (5,1)+(6,3) returns (10,6) with normal latency.
- Width stress: p=61, a=60, (60,60),(60,60) doubling → output matches the golden model. No truncation in 3·x² + a.

Source files
------------

// File: rtl/ecc_point_add.sv
// rtl/ecc_point_add.sv - sequential elliptic-curve point addition/doubling over GF(p)
//
// INV_IP: combinational modular inverse.
//   IN_1  value to invert (< IN_2)
//   IN_2  modulus
//   OUT   IN_1^-1 mod IN_2, or 0 when no inverse exists
//
// ecc_point_add: R = P + Q, or R = 2P when P = Q.
//   clk, rst_n           clock, async active-low reset
//   in_valid             two-beat input strobe
//   in_x, in_y           beat 1: (x1,y1); beat 2: (x2,y2)
//   in_prime, in_a       p and a, sampled on beat 1
//   out_valid            one-cycle result strobe
//   out_x, out_y         result coordinates, 0 when out_valid is low

module INV_IP #(
  parameter int IP_WIDTH = 6
) (
  input  logic [IP_WIDTH-1:0] IN_1,
  input  logic [IP_WIDTH-1:0] IN_2,
  output logic [IP_WIDTH-1:0] OUT
);

  // Exhaustive search: the first k with IN_1*k == 1 (mod IN_2).
  always_comb begin : inv_search
    logic                      found;
    logic [2*IP_WIDTH-1:0]     prod;
    OUT   = '0;
    found = 1'b0;
    prod  = '0;
    for (int k = 1; k < (1 << IP_WIDTH); k++) begin
      prod = {{IP_WIDTH{1'b0}}, IN_1} * {{IP_WIDTH{1'b0}}, IP_WIDTH'(k)};
      if (!found && (IN_2 != '0) &&
          ((prod % {{IP_WIDTH{1'b0}}, IN_2}) == {{(2*IP_WIDTH-1){1'b0}}, 1'b1})) begin
        OUT   = IP_WIDTH'(k);
        found = 1'b1;
      end
    end
  end

endmodule

module ecc_point_add #(
  parameter int WIDTH = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_x,
  input  logic [WIDTH-1:0] in_y,
  input  logic [WIDTH-1:0] in_prime,
  input  logic [WIDTH-1:0] in_a,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_x,
  output logic [WIDTH-1:0] out_y
);

  localparam int TW = 2 * WIDTH + 2;

  typedef enum logic [2:0] {IDLE, BEAT2, PREP, SLOPE, XCALC, OUT} state_t;

  state_t           state_q;
  logic [WIDTH-1:0] x1_q, y1_q, x2_q, y2_q, p_q, a_q;
  logic [WIDTH-1:0] num_q, den_q, s_q, x3_q;
  logic             deg_q;
  logic             out_valid_q;
  logic [WIDTH-1:0] out_x_q, out_y_q;

  logic [WIDTH-1:0] num_d, den_d, s_d, x3_d, y3_d;
  logic [WIDTH-1:0] inv;
  logic             is_dbl;
  logic [TW-1:0]    tri_sq;

  // Operands are < p, so one conditional +p brings the difference back into range.
  function automatic logic [WIDTH-1:0] mod_sub(input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b,
                                               input logic [WIDTH-1:0] p);
    return (a >= b) ? WIDTH'({1'b0, a} - {1'b0, b})
                    : WIDTH'({1'b0, a} + {1'b0, p} - {1'b0, b});
  endfunction

  function automatic logic [WIDTH-1:0] mod_mul(input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b,
                                               input logic [WIDTH-1:0] p);
    logic [2*WIDTH-1:0] pr;
    pr = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
    return WIDTH'(pr % {{WIDTH{1'b0}}, p});
  endfunction

  INV_IP #(.IP_WIDTH(WIDTH)) u_inv (
    .IN_1 (den_q),
    .IN_2 (p_q),
    .OUT  (inv)
  );

  always_comb begin
    is_dbl = (x1_q == x2_q) && (y1_q == y2_q);
    tri_sq = TW'(3) * TW'(x1_q) * TW'(x1_q) + TW'(a_q);
    if (is_dbl) begin
      num_d = WIDTH'(tri_sq % TW'(p_q));
      den_d = WIDTH'({y1_q, 1'b0} % {1'b0, p_q});
    end else begin
      num_d = mod_sub(y2_q, y1_q, p_q);
      den_d = mod_sub(x2_q, x1_q, p_q);
    end
    s_d  = mod_mul(num_q, inv, p_q);
    x3_d = mod_sub(mod_sub(mod_mul(s_q, s_q, p_q), x1_q, p_q), x2_q, p_q);
    y3_d = mod_sub(mod_mul(s_q, mod_sub(x1_q, x3_q, p_q), p_q), y1_q, p_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      x1_q        <= '0;
      y1_q        <= '0;
      x2_q        <= '0;
      y2_q        <= '0;
      p_q         <= '0;
      a_q         <= '0;
      num_q       <= '0;
      den_q       <= '0;
      s_q         <= '0;
      x3_q        <= '0;
      deg_q       <= 1'b0;
      out_valid_q <= 1'b0;
      out_x_q     <= '0;
      out_y_q     <= '0;
    end else begin
      // Result is a one-cycle pulse; the outputs are zero every other cycle.
      out_valid_q <= 1'b0;
      out_x_q     <= '0;
      out_y_q     <= '0;
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            x1_q    <= in_x;
            y1_q    <= in_y;
            p_q     <= in_prime;
            a_q     <= in_a;
            state_q <= BEAT2;
          end
        end
        BEAT2: begin
          x2_q    <= in_x;
          y2_q    <= in_y;
          state_q <= PREP;
        end
        PREP: begin
          num_q   <= num_d;
          den_q   <= den_d;
          // P = -Q or a vertical tangent: no finite slope, result forced to 0.
          deg_q   <= (den_d == '0);
          state_q <= SLOPE;
        end
        SLOPE: begin
          s_q     <= s_d;
          state_q <= XCALC;
        end
        XCALC: begin
          x3_q    <= x3_d;
          state_q <= OUT;
        end
        OUT: begin
          out_valid_q <= 1'b1;
          out_x_q     <= deg_q ? '0 : x3_q;
          out_y_q     <= deg_q ? '0 : y3_d;
          state_q     <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign out_valid = out_valid_q;
  assign out_x     = out_x_q;
  assign out_y     = out_y_q;

endmodule
